regfile_wr_arbiter: RTL and testbench
=====================================

Name: regfile_wr_arbiter

Overview:
Arbitrates the single general-register-file write port between the in-order pipeline writeback and a long-latency unit (mul/div, uncached load). The long-latency unit is reached through a valid/ready handshake.
Keeps a 32-bit pending-write scoreboard so issue logic can stall on RAW/WAW against in-flight long ops.
Sits between the WB stage / long unit and the regfile write port (we/waddr/wdata).

Parameters:
STARVE_LIMIT, 4, consecutive cycles the long unit may be refused before the pipeline is held
CNT_W, 3, width of starvation counter; must satisfy 2^CNT_W > STARVE_LIMIT

Ports:
clk  in  1  clock; all state on posedge
resetn  in  1  reset; one clock; reset is asynchronous and active-low
pipe_we  in  1  pipeline writeback valid (cannot be back-pressured in the same cycle)
pipe_waddr  in  5  pipeline destination
pipe_wdata  in  32  pipeline data
pipe_hold  out  1  registered; pipeline must present pipe_we=0 in the following cycle
pend_set  in  1  long op issued this cycle
pend_addr  in  5  its destination
lu_valid  in  1  long unit result valid
lu_ready  out  1  combinational grant to long unit
lu_waddr  in  5  long unit destination
lu_wdata  in  32  long unit data
busy_vec  out  32  registered scoreboard, bit i = write to reg i pending
rf_we  out  1  registered write enable to regfile
rf_waddr  out  5  registered
rf_wdata  out  32  registered

Behaviour:
- Reset: rf_we=0, rf_waddr=0, rf_wdata=0, busy_vec=0, pipe_hold=0, starve counter=0. Asserting resetn low mid-operation discards in-flight grants and clears the scoreboard immediately.
- Latency: winner presented at cycle N, appears on rf_* at N+1.
- Arbitration, fixed priority: pipe_we=1 wins. lu_ready = lu_valid & ~pipe_we (combinational). Handshake completes when lu_valid & lu_ready. lu_* must be held stable while lu_valid=1 and lu_ready=0.
- Neither source active: rf_we=0 next cycle; rf_waddr/rf_wdata hold their previous values.
- Address 0, either source: accepted/granted normally, but rf_we=0 next cycle, and busy bit 0 is never set.
- Starvation counter:
  - Increments each cycle lu_valid=1 and lu_ready=0; saturates at STARVE_LIMIT.
  - Clears on any LU handshake or lu_valid=0.
  - pipe_hold is registered = (counter reaches STARVE_LIMIT this cycle), so it is asserted the next cycle.
  - While pipe_hold=1 the pipeline drives pipe_we=0, so the LU wins. pipe_hold drops the cycle after the handshake.
  - If pipe_we=1 anyway while pipe_hold=1: pipe still wins (protocol violation, flagged by assertion).
- Scoreboard:
  - Handshake with lu_waddr=k clears busy[k].
  - pend_set with pend_addr=k sets busy[k].
  - Set and clear of the same k in one cycle: set wins.
  - pend_set to an already-busy k: stays 1. This is an issue-logic WAW, flagged by assertion.
  - Pipeline writes never modify busy_vec.
- busy_vec updates on the clock edge; the issue stage sees the new state the next cycle.

Optional Feature:
RF_ARB_PERF_EN
- Defined: adds outputs perf_lu_wait (32) and perf_hold (32), both reset to 0 and wrapping modulo 2^32.
  - perf_lu_wait counts cycles with lu_valid & ~lu_ready.
  - perf_hold counts cycles pipe_hold=1.
- Undefined: ports and counters absent; all other behaviour identical.

Decomposition:
- Shared package/Defines header: REG_ADDR_W=5, REG_DATA_W=32, REG_NUM=32, REG_ZERO=5'd0.
- One natural sub-module, reg_scoreboard: set/clear ports plus busy_vec, containing the set-wins rule. The arbiter and starvation counter stay in the top.

Test Plan:
- Reset with resetn=0 while lu_valid=1, pend_set=1 -> all outputs 0, busy_vec=0; after release, first write appears one cycle after presentation.
- pipe_we=1 waddr=5 data=0x1234 with lu_valid=1 waddr=7 -> lu_ready=0; next cycle rf_we=1, rf_waddr=5, rf_wdata=0x1234. Pipe idle the following cycle -> LU handshakes, then rf_waddr=7.
- pend_set addr=9 -> busy_vec=0x200. LU handshake addr=9 -> busy_vec=0 next cycle. Same-cycle pend_set 9 with LU clear 9 -> busy_vec[9] stays 1.
- lu_valid=1 and pipe_we=1 every cycle, STARVE_LIMIT=4 -> pipe_hold=1 after 4 refused cycles. Bench drops pipe_we -> LU granted, pipe_hold=0 the cycle after.
- Pipe write to addr 0 with data 0xFFFFFFFF -> rf_we=0. LU write to addr 0 -> lu_ready=1, rf_we=0, busy_vec[0] stays 0.
- RF_ARB_PERF_EN defined, 3 refused LU cycles -> perf_lu_wait=3. Macro undefined -> build has no perf ports.

Source files
------------

// File: rtl/regfile_wr_arbiter_pkg.sv
// regfile_wr_arbiter_pkg: shared register-file widths, types and helpers.
package regfile_wr_arbiter_pkg;
    localparam int REG_ADDR_W = 5;
    localparam int REG_DATA_W = 32;
    localparam int REG_NUM = 32;
    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [REG_DATA_W-1:0] reg_data_t;
    localparam reg_addr_t REG_ZERO = 5'd0;
    function automatic logic [REG_NUM-1:0] onehot(input reg_addr_t a);
        return REG_NUM'(1) << a;
    endfunction
endpackage

// File: rtl/regfile_wr_arbiter_if.sv
// regfile_wr_arbiter_if: pipeline, long-unit, scoreboard and regfile-port signals.
// RF_ARB_PERF_EN adds the perf_lu_wait/perf_hold counters.
interface regfile_wr_arbiter_if;
    import regfile_wr_arbiter_pkg::*;
    logic pipe_we;
    reg_addr_t pipe_waddr;
    reg_data_t pipe_wdata;
    logic pipe_hold;
    logic pend_set;
    reg_addr_t pend_addr;
    logic lu_valid;
    logic lu_ready;
    reg_addr_t lu_waddr;
    reg_data_t lu_wdata;
    logic [REG_NUM-1:0] busy_vec;
    logic rf_we;
    reg_addr_t rf_waddr;
    reg_data_t rf_wdata;
`ifdef RF_ARB_PERF_EN
    logic [31:0] perf_lu_wait;
    logic [31:0] perf_hold;
`endif
    modport master(
        output pipe_we, pipe_waddr, pipe_wdata, pend_set, pend_addr, lu_valid, lu_waddr, lu_wdata,
        input pipe_hold, lu_ready, busy_vec, rf_we, rf_waddr, rf_wdata
`ifdef RF_ARB_PERF_EN
        , input perf_lu_wait, perf_hold
`endif
    );
    modport slave(
        input pipe_we, pipe_waddr, pipe_wdata, pend_set, pend_addr, lu_valid, lu_waddr, lu_wdata,
        output pipe_hold, lu_ready, busy_vec, rf_we, rf_waddr, rf_wdata
`ifdef RF_ARB_PERF_EN
        , output perf_lu_wait, perf_hold
`endif
    );
endinterface

// File: rtl/regfile_wr_arbiter_reg_scoreboard.sv
// regfile_wr_arbiter_reg_scoreboard: pending-write bit per register; a set beats a same-cycle clear.
module regfile_wr_arbiter_reg_scoreboard
    import regfile_wr_arbiter_pkg::*;
(
    input logic clk,
    input logic resetn,
    input logic set,
    input reg_addr_t set_addr,
    input logic clr,
    input reg_addr_t clr_addr,
    output logic [REG_NUM-1:0] busy_vec
);
    logic [REG_NUM-1:0] set_mask;
    logic [REG_NUM-1:0] clr_mask;
    always_comb begin
        set_mask = (set && set_addr != REG_ZERO) ? onehot(set_addr) : '0;
        clr_mask = clr ? onehot(clr_addr) : '0;
    end
    always_ff @(posedge clk or negedge resetn)
        if (!resetn) busy_vec <= '0;
        else busy_vec <= (busy_vec & ~clr_mask) | set_mask;
    // Reissuing to a register whose long op is still outstanding is an issue-logic WAW bug.
    a_no_waw: assert property (@(posedge clk) disable iff (!resetn)
        !(set && set_addr != REG_ZERO && busy_vec[set_addr] && !(clr && clr_addr == set_addr)));
endmodule

// File: rtl/regfile_wr_arbiter.sv
// regfile_wr_arbiter: fixed-priority regfile write arbiter (pipeline over long unit) with
// starvation hold and pending-write scoreboard. RF_ARB_PERF_EN adds perf counters.
module regfile_wr_arbiter
    import regfile_wr_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W = 3
) (
    input logic clk,
    input logic resetn,
    regfile_wr_arbiter_if.slave bus
);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);
    logic lu_hs;
    logic sel_we;
    reg_addr_t sel_addr;
    reg_data_t sel_data;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    assign bus.lu_ready = bus.lu_valid & ~bus.pipe_we;
    always_comb begin
        lu_hs = bus.lu_valid & bus.lu_ready;
        sel_we = bus.pipe_we | lu_hs;
        sel_addr = bus.pipe_we ? bus.pipe_waddr : bus.lu_waddr;
        sel_data = bus.pipe_we ? bus.pipe_wdata : bus.lu_wdata;
        cnt_nxt = (bus.lu_valid && !bus.lu_ready) ? ((cnt == LIMIT) ? cnt : cnt + CNT_W'(1)) : '0;
    end
    always_ff @(posedge clk or negedge resetn)
        if (!resetn) begin
            bus.rf_we <= 1'b0;
            bus.rf_waddr <= '0;
            bus.rf_wdata <= '0;
            bus.pipe_hold <= 1'b0;
            cnt <= '0;
        end else begin
            bus.rf_we <= sel_we && sel_addr != REG_ZERO;
            if (sel_we) begin
                bus.rf_waddr <= sel_addr;
                bus.rf_wdata <= sel_data;
            end
            cnt <= cnt_nxt;
            bus.pipe_hold <= cnt_nxt == LIMIT;
        end
    regfile_wr_arbiter_reg_scoreboard u_sb (
        .clk(clk),
        .resetn(resetn),
        .set(bus.pend_set),
        .set_addr(bus.pend_addr),
        .clr(lu_hs),
        .clr_addr(bus.lu_waddr),
        .busy_vec(bus.busy_vec)
    );
`ifdef RF_ARB_PERF_EN
    always_ff @(posedge clk or negedge resetn)
        if (!resetn) begin
            bus.perf_lu_wait <= '0;
            bus.perf_hold <= '0;
        end else begin
            if (bus.lu_valid && !bus.lu_ready) bus.perf_lu_wait <= bus.perf_lu_wait + 32'd1;
            if (bus.pipe_hold) bus.perf_hold <= bus.perf_hold + 32'd1;
        end
`endif
    // The pipeline still wins if it ignores pipe_hold, but that is a protocol violation.
    a_hold_respected: assert property (@(posedge clk) disable iff (!resetn) !(bus.pipe_we && bus.pipe_hold));
endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// tb_regfile_wr_arbiter: directed steps with a queue of expected regfile writes.
module tb_regfile_wr_arbiter;
    logic clk = 1'b0;
    logic resetn;
    regfile_wr_arbiter_if bus();
    regfile_wr_arbiter #(.STARVE_LIMIT(4), .CNT_W(3)) dut (
        .clk(clk),
        .resetn(resetn),
        .bus(bus.slave)
    );
    always #5 clk = ~clk;
    typedef struct packed {
        logic we;
        logic chk_ad;
        logic [4:0] a;
        logic [31:0] d;
    } wr_t;
    wr_t exp_q[$];
    int checks = 0;
    int errors = 0;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    task automatic push(input logic we, input logic chk_ad, input logic [4:0] a, input logic [31:0] d);
        exp_q.push_back('{we: we, chk_ad: chk_ad, a: a, d: d});
    endtask
    task automatic drive(input logic pwe, input logic [4:0] pa, input logic [31:0] pd,
                         input logic lv, input logic [4:0] la, input logic [31:0] ld,
                         input logic ps, input logic [4:0] psa);
        bus.pipe_we = pwe;
        bus.pipe_waddr = pa;
        bus.pipe_wdata = pd;
        bus.lu_valid = lv;
        bus.lu_waddr = la;
        bus.lu_wdata = ld;
        bus.pend_set = ps;
        bus.pend_addr = psa;
    endtask
    task automatic tick();
        wr_t e;
        @(posedge clk);
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("rf_we", {31'd0, bus.rf_we}, {31'd0, e.we});
            if (e.chk_ad) begin
                chk("rf_waddr", {27'd0, bus.rf_waddr}, {27'd0, e.a});
                chk("rf_wdata", bus.rf_wdata, e.d);
            end
        end
    endtask
    initial begin
        resetn = 1'b0;
        drive(0, 0, 0, 1, 5'd7, 32'h77, 1, 5'd3);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rf_we", {31'd0, bus.rf_we}, 0);
        chk("rst_rf_waddr", {27'd0, bus.rf_waddr}, 0);
        chk("rst_rf_wdata", bus.rf_wdata, 0);
        chk("rst_busy", bus.busy_vec, 0);
        chk("rst_hold", {31'd0, bus.pipe_hold}, 0);
        resetn = 1'b1;
        // pipe beats a waiting long-unit result
        drive(1, 5'd5, 32'h1234, 1, 5'd7, 32'hBEEF, 0, 0);
        #1;
        chk("lu_ready_refused", {31'd0, bus.lu_ready}, 0);
        push(1, 1, 5'd5, 32'h1234);
        tick();
        drive(0, 0, 0, 1, 5'd7, 32'hBEEF, 0, 0);
        #1;
        chk("lu_ready_grant", {31'd0, bus.lu_ready}, 1);
        push(1, 1, 5'd7, 32'hBEEF);
        tick();
        chk("busy_after_writes", bus.busy_vec, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        push(0, 1, 5'd7, 32'hBEEF);
        tick();
        // scoreboard set, clear, set-wins
        drive(0, 0, 0, 0, 0, 0, 1, 5'd9);
        push(0, 1, 5'd7, 32'hBEEF);
        tick();
        chk("busy_set9", bus.busy_vec, 32'h200);
        drive(0, 0, 0, 1, 5'd9, 32'h99, 0, 0);
        push(1, 1, 5'd9, 32'h99);
        tick();
        chk("busy_clr9", bus.busy_vec, 0);
        drive(0, 0, 0, 1, 5'd9, 32'hAA, 1, 5'd9);
        push(1, 1, 5'd9, 32'hAA);
        tick();
        chk("busy_setwins", bus.busy_vec, 32'h200);
        drive(0, 0, 0, 1, 5'd9, 32'hAB, 0, 0);
        push(1, 1, 5'd9, 32'hAB);
        tick();
        chk("busy_reclr9", bus.busy_vec, 0);
        // starvation: four refused cycles raise pipe_hold
        for (int i = 0; i < 4; i++) begin
            drive(1, 5'd3, 32'h300 + i, 1, 5'd4, 32'h44, 0, 0);
            push(1, 1, 5'd3, 32'h300 + i);
            tick();
            chk("starve_hold", {31'd0, bus.pipe_hold}, (i == 3) ? 1 : 0);
        end
        drive(0, 0, 0, 1, 5'd4, 32'h44, 0, 0);
        #1;
        chk("lu_ready_held", {31'd0, bus.lu_ready}, 1);
        push(1, 1, 5'd4, 32'h44);
        tick();
        chk("hold_drop", {31'd0, bus.pipe_hold}, 0);
        // address 0 from either source never writes and never marks busy
        drive(1, 5'd0, 32'hFFFF_FFFF, 0, 0, 0, 0, 0);
        push(0, 0, 0, 0);
        tick();
        drive(0, 0, 0, 1, 5'd0, 32'h55, 1, 5'd0);
        #1;
        chk("lu_ready_zero", {31'd0, bus.lu_ready}, 1);
        push(0, 0, 0, 0);
        tick();
        chk("busy_zero", bus.busy_vec, 0);
        for (int i = 0; i < 3; i++) begin
            drive(1, 5'd6, 32'h600 + i, 1, 5'd8, 32'h88, 0, 0);
            push(1, 1, 5'd6, 32'h600 + i);
            tick();
        end
        chk("hold_below_limit", {31'd0, bus.pipe_hold}, 0);
`ifdef RF_ARB_PERF_EN
        chk("perf_lu_wait", bus.perf_lu_wait, 8);
        chk("perf_hold", bus.perf_hold, 1);
`endif
        drive(0, 0, 0, 1, 5'd8, 32'h88, 0, 0);
        push(1, 1, 5'd8, 32'h88);
        tick();
        // asynchronous reset mid-cycle drops pending state
        drive(0, 0, 0, 0, 0, 0, 1, 5'd12);
        push(0, 1, 5'd8, 32'h88);
        tick();
        chk("busy_set12", bus.busy_vec, 32'h1000);
        drive(1, 5'd13, 32'hDEAD, 1, 5'd14, 32'hE, 1, 5'd2);
        #2;
        resetn = 1'b0;
        #1;
        exp_q.delete();
        chk("arst_rf_waddr", {27'd0, bus.rf_waddr}, 0);
        chk("arst_rf_wdata", bus.rf_wdata, 0);
        chk("arst_busy", bus.busy_vec, 0);
        tick();
        chk("arst_rf_we", {31'd0, bus.rf_we}, 0);
        chk("arst_busy_held", bus.busy_vec, 0);
        chk("arst_hold", {31'd0, bus.pipe_hold}, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        resetn = 1'b1;
        drive(1, 5'd17, 32'hCAFE, 0, 0, 0, 0, 0);
        push(1, 1, 5'd17, 32'hCAFE);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
